// File: rtl/ps2_mouse_init_ctrl_pkg.sv
// Shared constants, state/error encodings and state-mapping helpers for the
// PS/2 mouse initialisation sequencer.
package ps2_mouse_pkg;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_ERR      = 8'hFC;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_ID       = 8'h00;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEND_RESET,
        ST_WAIT_ACK_RESET,
        ST_WAIT_BAT,
        ST_WAIT_ID,
        ST_SEND_RATE_CMD,
        ST_WAIT_ACK_RATE_CMD,
        ST_SEND_RATE_VAL,
        ST_WAIT_ACK_RATE_VAL,
        ST_SEND_ENABLE,
        ST_WAIT_ACK_ENABLE,
        ST_STREAM,
        ST_ERROR
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_TIMEOUT    = 3'd1,
        ERR_TX         = 3'd2,
        ERR_DEV        = 3'd3,
        ERR_UNEXPECTED = 3'd4,
        ERR_RESEND     = 3'd5
    } err_code_t;

    function automatic logic is_send(input state_t s);
        return (s == ST_SEND_RESET) || (s == ST_SEND_RATE_CMD) ||
               (s == ST_SEND_RATE_VAL) || (s == ST_SEND_ENABLE);
    endfunction

    function automatic logic is_wait(input state_t s);
        return (s == ST_WAIT_ACK_RESET) || (s == ST_WAIT_BAT) || (s == ST_WAIT_ID) ||
               (s == ST_WAIT_ACK_RATE_CMD) || (s == ST_WAIT_ACK_RATE_VAL) ||
               (s == ST_WAIT_ACK_ENABLE);
    endfunction

    function automatic state_t send_to_wait(input state_t s);
        case (s)
            ST_SEND_RESET:    return ST_WAIT_ACK_RESET;
            ST_SEND_RATE_CMD: return ST_WAIT_ACK_RATE_CMD;
            ST_SEND_RATE_VAL: return ST_WAIT_ACK_RATE_VAL;
            ST_SEND_ENABLE:   return ST_WAIT_ACK_ENABLE;
            default:          return ST_IDLE;
        endcase
    endfunction

    function automatic state_t ack_to_next(input state_t s);
        case (s)
            ST_WAIT_ACK_RESET:    return ST_WAIT_BAT;
            ST_WAIT_ACK_RATE_CMD: return ST_SEND_RATE_VAL;
            ST_WAIT_ACK_RATE_VAL: return ST_SEND_ENABLE;
            ST_WAIT_ACK_ENABLE:   return ST_STREAM;
            default:              return ST_IDLE;
        endcase
    endfunction

    // A 0xFE reply asks for the byte that was just acknowledged-wait'ed on.
    function automatic state_t ack_to_resend(input state_t s);
        case (s)
            ST_WAIT_ACK_RESET:    return ST_SEND_RESET;
            ST_WAIT_ACK_RATE_CMD: return ST_SEND_RATE_CMD;
            ST_WAIT_ACK_RATE_VAL: return ST_SEND_RATE_VAL;
            ST_WAIT_ACK_ENABLE:   return ST_SEND_ENABLE;
            default:              return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/ps2_timeout_timer.sv
// Per-state response timer: cleared on state entry, counts while enabled and
// flags the last allowed cycle of the wait window.
module ps2_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 25_000_000
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (enable_i && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired_o = enable_i && (r_cnt == LAST);

endmodule

// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse initialisation sequencer: reset, BAT/ID check, sample rate,
// enable reporting, with response checking, retries and timeouts.
module ps2_mouse_init_ctrl
    import ps2_mouse_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 25_000_000,
    parameter int         MAX_RETRY      = 3,
    parameter logic [7:0] SAMPLE_RATE    = 8'd100,
    parameter bit         AUTO_START     = 1'b1
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       start_i,
    output logic       tx_req_o,
    output logic [7:0] tx_byte_o,
    input  logic       tx_done_i,
    input  logic       tx_err_i,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_byte_i,
    output logic       stream_en_o,
    output logic       busy_o,
    output logic       err_o,
    output logic [2:0] err_code_o
);

    localparam logic [2:0] LAST_RETRY = 3'(MAX_RETRY - 1);

    state_t    r_state, w_state_next, w_resend_state;
    logic [2:0] r_retry, w_retry_next;
    err_code_t r_err_code, w_code_next, w_fail_code;
    logic      w_enter, w_fail, w_resend, w_restart, w_expired;
    logic      r_tx_req, w_tx_req_next;
    logic [7:0] r_tx_byte, w_tx_byte_next;
    logic      r_stream, r_err, r_busy;

    ps2_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clear_i  (w_enter),
        .enable_i (is_send(r_state) || is_wait(r_state)),
        .expired_o(w_expired)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_retry_next   = r_retry;
        w_code_next    = r_err_code;
        w_enter        = 1'b0;
        w_fail         = 1'b0;
        w_fail_code    = ERR_NONE;
        w_resend       = 1'b0;
        w_resend_state = ack_to_resend(r_state);
        w_restart      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (AUTO_START || start_i) begin
                    w_restart = 1'b1;
                end
            end
            ST_SEND_RESET, ST_SEND_RATE_CMD, ST_SEND_RATE_VAL, ST_SEND_ENABLE: begin
                if (tx_err_i) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_TX;
                end else if (tx_done_i) begin
                    w_state_next = send_to_wait(r_state);
                    w_enter      = 1'b1;
                end else if (w_expired) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_TIMEOUT;
                end
            end
            ST_WAIT_ACK_RESET, ST_WAIT_ACK_RATE_CMD, ST_WAIT_ACK_RATE_VAL, ST_WAIT_ACK_ENABLE: begin
                if (rx_valid_i) begin
                    case (rx_byte_i)
                        RSP_ACK: begin
                            w_state_next = ack_to_next(r_state);
                            w_enter      = 1'b1;
                        end
                        RSP_RESEND: w_resend = 1'b1;
                        RSP_ERR: begin
                            w_fail      = 1'b1;
                            w_fail_code = ERR_DEV;
                        end
                        default: begin
                            w_fail      = 1'b1;
                            w_fail_code = ERR_UNEXPECTED;
                        end
                    endcase
                end else if (w_expired) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_TIMEOUT;
                end
            end
            ST_WAIT_BAT, ST_WAIT_ID: begin
                if (rx_valid_i) begin
                    if (rx_byte_i == ((r_state == ST_WAIT_BAT) ? RSP_BAT_OK : RSP_ID)) begin
                        w_state_next = (r_state == ST_WAIT_BAT) ? ST_WAIT_ID : ST_SEND_RATE_CMD;
                        w_enter      = 1'b1;
                    end else begin
                        w_fail      = 1'b1;
                        w_fail_code = (rx_byte_i == RSP_ERR) ? ERR_DEV : ERR_UNEXPECTED;
                    end
                end else if (w_expired) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_TIMEOUT;
                end
            end
            ST_STREAM, ST_ERROR: begin
                if (start_i) begin
                    w_restart = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        // Retries are shared by the whole sequence, so a 0xFE anywhere eats into the same budget.
        if (w_fail) begin
            w_code_next = w_fail_code;
            if (r_retry == LAST_RETRY) begin
                w_state_next = ST_ERROR;
            end else begin
                w_retry_next = r_retry + 3'd1;
                w_state_next = ST_SEND_RESET;
                w_enter      = 1'b1;
            end
        end
        if (w_resend) begin
            if (r_retry == LAST_RETRY) begin
                w_code_next  = ERR_RESEND;
                w_state_next = ST_ERROR;
            end else begin
                w_retry_next = r_retry + 3'd1;
                w_state_next = w_resend_state;
                w_enter      = 1'b1;
            end
        end
        if (w_restart) begin
            w_retry_next = 3'd0;
            w_code_next  = ERR_NONE;
            w_state_next = ST_SEND_RESET;
            w_enter      = 1'b1;
        end

        // Request rises one cycle into a send state and falls with the cycle that leaves it.
        w_tx_req_next = is_send(r_state) && (w_state_next == r_state) && !w_enter;
        case (r_state)
            ST_SEND_RESET:    w_tx_byte_next = CMD_RESET;
            ST_SEND_RATE_CMD: w_tx_byte_next = CMD_SET_RATE;
            ST_SEND_RATE_VAL: w_tx_byte_next = SAMPLE_RATE;
            ST_SEND_ENABLE:   w_tx_byte_next = CMD_ENABLE;
            default:          w_tx_byte_next = r_tx_byte;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_retry    <= 3'd0;
            r_err_code <= ERR_NONE;
            r_tx_req   <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_stream   <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_retry    <= w_retry_next;
            r_err_code <= w_code_next;
            r_tx_req   <= w_tx_req_next;
            r_tx_byte  <= w_tx_byte_next;
            r_stream   <= (w_state_next == ST_STREAM);
            r_err      <= (w_state_next == ST_ERROR);
            r_busy     <= (w_state_next != ST_IDLE) && (w_state_next != ST_STREAM) &&
                          (w_state_next != ST_ERROR);
        end
    end

    assign tx_req_o    = r_tx_req;
    assign tx_byte_o   = r_tx_byte;
    assign stream_en_o = r_stream;
    assign err_o       = r_err;
    assign busy_o      = r_busy;
    assign err_code_o  = r_err_code;

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// Bench for ps2_mouse_init_ctrl: scripted transceiver/mouse responder, a
// transaction-level model of the init protocol, and a per-cycle checker.
module tb_ps2_mouse_init_ctrl;

    localparam int MAXR = 3;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start_i;
    logic       tx_req_o;
    logic [7:0] tx_byte_o;
    logic       tx_done_i;
    logic       tx_err_i;
    logic       rx_valid_i;
    logic [7:0] rx_byte_i;
    logic       stream_en_o;
    logic       busy_o;
    logic       err_o;
    logic [2:0] err_code_o;

    always #5 clk = ~clk;

    ps2_mouse_init_ctrl #(
        .TIMEOUT_CYCLES(1000),
        .MAX_RETRY     (MAXR),
        .SAMPLE_RATE   (8'd100),
        .AUTO_START    (1'b1)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .start_i    (start_i),
        .tx_req_o   (tx_req_o),
        .tx_byte_o  (tx_byte_o),
        .tx_done_i  (tx_done_i),
        .tx_err_i   (tx_err_i),
        .rx_valid_i (rx_valid_i),
        .rx_byte_i  (rx_byte_i),
        .stream_en_o(stream_en_o),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .err_code_o (err_code_o)
    );

    // One script entry per transmit attempt: default device replies, or a forced outcome.
    typedef struct {
        bit              dflt;
        bit              txerr;
        int              delay;
        int              nrep;
        logic [2:0][7:0] rep;
    } ent_t;

    ent_t       script_q [$];
    ent_t       dflt_ent;
    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];
    int         exp_done, exp_code, exp_len, done_cnt;
    bit         exp_stream;
    int         total = 0;
    int         bad = 0;
    int         req_cnt = 0;
    logic       prev_req = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, want);
        end
    endtask

    function automatic ent_t mk(input bit d, input bit te, input int dl, input int n,
                                input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
        ent_t e;
        e.dflt = d; e.txerr = te; e.delay = dl; e.nrep = n;
        e.rep[0] = r0; e.rep[1] = r1; e.rep[2] = r2;
        return e;
    endfunction

    // A well-behaved mouse: ACK everything, plus BAT pass and ID after a reset command.
    function automatic ent_t fill(input logic [7:0] b, input ent_t e_in);
        ent_t e;
        e = e_in;
        if (b == 8'hFF) begin
            e.nrep = 3; e.rep[0] = 8'hFA; e.rep[1] = 8'hAA; e.rep[2] = 8'h00;
        end else begin
            e.nrep = 1; e.rep[0] = 8'hFA;
        end
        return e;
    endfunction

    // Protocol model: walks the command list against the script, no cycle timing involved.
    task automatic model_run();
        ent_t       s [$];
        ent_t       e;
        logic [7:0] seq [4];
        logic [7:0] want [3];
        int         idx, retry, outcome, nwant;
        bit         fin;
        seq  = '{8'hFF, 8'hF3, 8'd100, 8'hF4};
        want = '{8'hFA, 8'hAA, 8'h00};
        s = script_q;
        exp_q.delete();
        exp_done = 0; exp_code = 0; exp_stream = 1'b0; done_cnt = 0;
        idx = 0; retry = 0; fin = 1'b0;
        while (!fin) begin
            exp_q.push_back(seq[idx]);
            if (s.size() != 0) e = s.pop_front();
            else e = dflt_ent;
            if (e.dflt) e = fill(seq[idx], e);
            outcome = 0;
            if (e.txerr) begin
                outcome = 2;
            end else begin
                exp_done++;
                nwant = (seq[idx] == 8'hFF) ? 3 : 1;
                for (int j = 0; j < nwant && outcome == 0; j++) begin
                    if (j >= e.nrep) outcome = 1;
                    else if (e.rep[j] != want[j]) begin
                        if (j == 0 && e.rep[j] == 8'hFE) outcome = 9;
                        else if (e.rep[j] == 8'hFC) outcome = 3;
                        else outcome = 4;
                    end
                end
            end
            if (outcome == 0) begin
                idx++;
                if (idx == 4) begin exp_stream = 1'b1; fin = 1'b1; end
            end else if (outcome == 9) begin
                if (retry == MAXR - 1) begin exp_code = 5; fin = 1'b1; end
                else retry++;
            end else begin
                exp_code = outcome;
                if (retry == MAXR - 1) fin = 1'b1;
                else begin retry++; idx = 0; end
            end
        end
        exp_len = exp_q.size();
    endtask

    // Transceiver + mouse responder, driven just after the active edge.
    initial begin
        ent_t e;
        tx_done_i = 1'b0; tx_err_i = 1'b0; rx_valid_i = 1'b0; rx_byte_i = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            tx_done_i = 1'b0; tx_err_i = 1'b0; rx_valid_i = 1'b0;
            if (!rstn) begin
                req_cnt = 0;
                rx_q.delete();
            end else begin
                if (rx_q.size() != 0) begin
                    rx_valid_i = 1'b1;
                    rx_byte_i  = rx_q.pop_front();
                end
                if (tx_req_o) begin
                    req_cnt++;
                    e = (script_q.size() != 0) ? script_q[0] : dflt_ent;
                    if (req_cnt >= e.delay) begin
                        if (script_q.size() != 0) e = script_q.pop_front();
                        req_cnt = 0;
                        tx_done_i = 1'b1;
                        if (e.txerr) begin
                            tx_err_i = 1'b1;
                        end else begin
                            if (e.dflt) e = fill(tx_byte_o, e);
                            for (int j = 0; j < e.nrep; j++) rx_q.push_back(e.rep[j]);
                        end
                    end
                end else begin
                    req_cnt = 0;
                end
            end
        end
    end

    // Per-cycle checker against the model's expected transmit stream and output rules.
    always @(negedge clk) begin
        if (rstn) begin
            chk("status_exclusive", int'(stream_en_o) + int'(err_o) + int'(busy_o) <= 1 ? 1 : 0, 1);
            if (tx_req_o) chk("req_implies_busy", int'(busy_o), 1);
            if (tx_req_o && prev_req) chk("tx_byte_stable", int'(tx_byte_o), int'(prev_byte));
            if (tx_req_o && (tx_done_i || tx_err_i)) begin
                if (exp_q.size() == 0) chk("tx_unexpected", int'(tx_byte_o), -1);
                else chk("tx_byte", int'(tx_byte_o), int'(exp_q.pop_front()));
                if (tx_done_i && !tx_err_i) done_cnt++;
            end
        end
        prev_req  = tx_req_o;
        prev_byte = tx_byte_o;
    end

    task automatic check_reset(input string tag);
        chk({tag, "_tx_req"}, int'(tx_req_o), 0);
        chk({tag, "_tx_byte"}, int'(tx_byte_o), 0);
        chk({tag, "_stream"}, int'(stream_en_o), 0);
        chk({tag, "_busy"}, int'(busy_o), 0);
        chk({tag, "_err"}, int'(err_o), 0);
        chk({tag, "_code"}, int'(err_code_o), 0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_finished"}, int'(busy_o), 0);
    endtask

    task automatic check_final(input string tag);
        chk({tag, "_stream"}, int'(stream_en_o), int'(exp_stream));
        chk({tag, "_err"}, int'(err_o), exp_stream ? 0 : 1);
        chk({tag, "_code"}, int'(err_code_o), exp_code);
        chk({tag, "_tx_req"}, int'(tx_req_o), 0);
        chk({tag, "_tx_left"}, exp_q.size(), 0);
        chk({tag, "_done_pulses"}, done_cnt, exp_done);
    endtask

    task automatic pulse_start();
        @(negedge clk) start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
    endtask

    initial begin
        int n;
        rstn = 1'b0;
        start_i = 1'b0;
        dflt_ent = mk(1'b1, 1'b0, 3, 0, 8'h00, 8'h00, 8'h00);

        // 1: happy path after reset with auto start
        script_q.delete();
        model_run();
        chk("m1_len", exp_len, 4);
        chk("m1_b0", int'(exp_q[0]), 'hFF);
        chk("m1_b1", int'(exp_q[1]), 'hF3);
        chk("m1_b2", int'(exp_q[2]), 'h64);
        chk("m1_b3", int'(exp_q[3]), 'hF4);
        repeat (3) @(negedge clk);
        check_reset("rst0");
        rstn = 1'b1;
        wait_idle("s1", 20000);
        check_final("s1");
        chk("s1_busy", int'(busy_o), 0);

        // 2: first reply to 0xF3 is a resend request
        script_q.delete();
        script_q.push_back(dflt_ent);
        script_q.push_back(mk(1'b0, 1'b0, 3, 1, 8'hFE, 8'h00, 8'h00));
        model_run();
        chk("m2_len", exp_len, 5);
        chk("m2_done", exp_done, 5);
        pulse_start();
        wait_idle("s2", 20000);
        check_final("s2");

        // 3: silent device, timeouts exhaust the retries
        script_q.delete();
        repeat (3) script_q.push_back(mk(1'b0, 1'b0, 3, 0, 8'h00, 8'h00, 8'h00));
        model_run();
        chk("m3_len", exp_len, 3);
        chk("m3_code", exp_code, 1);
        pulse_start();
        wait_idle("s3", 20000);
        check_final("s3");

        // 5: restart from ERROR with a good device, then stray packet byte in STREAM
        script_q.delete();
        model_run();
        pulse_start();
        chk("s5_busy_next", int'(busy_o), 1);
        chk("s5_err_next", int'(err_o), 0);
        chk("s5_code_next", int'(err_code_o), 0);
        wait_idle("s5", 20000);
        check_final("s5");
        rx_q.push_back(8'h08);
        repeat (6) begin
            @(negedge clk);
            chk("s5_hold_stream", int'(stream_en_o), 1);
            chk("s5_hold_no_req", int'(tx_req_o), 0);
        end

        // 4: 0xFC in place of the BAT result, code retained until next start
        script_q.delete();
        script_q.push_back(mk(1'b0, 1'b0, 3, 2, 8'hFA, 8'hFC, 8'h00));
        model_run();
        chk("m4_len", exp_len, 5);
        chk("m4_code", exp_code, 3);
        pulse_start();
        wait_idle("s4", 20000);
        check_final("s4");
        repeat (4) begin
            @(negedge clk);
            chk("s4_code_kept", int'(err_code_o), 3);
        end
        script_q.delete();
        model_run();
        pulse_start();
        chk("s4_code_cleared", int'(err_code_o), 0);
        wait_idle("s4b", 20000);
        check_final("s4b");

        // 7: tx_err and tx_done together on the first reset command
        script_q.delete();
        script_q.push_back(mk(1'b0, 1'b1, 3, 0, 8'h00, 8'h00, 8'h00));
        model_run();
        chk("m7_done", exp_done, 4);
        chk("m7_code", exp_code, 2);
        pulse_start();
        wait_idle("s7", 20000);
        check_final("s7");

        // 6: reset mid-transmission, then tx_done in the timeout cycle
        script_q.delete();
        model_run();
        pulse_start();
        n = 0;
        while (!tx_req_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("s6_req_seen", int'(tx_req_o), 1);
        #2 rstn = 1'b0;
        #1 check_reset("s6_rst");
        repeat (3) @(negedge clk);
        script_q.delete();
        script_q.push_back(mk(1'b1, 1'b0, 999, 0, 8'h00, 8'h00, 8'h00));
        model_run();
        rstn = 1'b1;
        wait_idle("s6", 20000);
        check_final("s6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_init_ctrl.md
Name: ps2_mouse_init_ctrl

Overview:
Command sequencer for the PS/2 mouse. After reset, or on request, it drives a byte-level PS/2 host transceiver through the standard initialisation: reset, self-test, set sample rate, enable data reporting. It checks every device response, retries on errors, and enforces timeouts. stream_en_o gates the mouse position/button accumulator, so movement packets are only consumed once the device is in stream mode.

Parameters:
TIMEOUT_CYCLES, 25_000_000, per-response wait limit in clk_i cycles (500 ms at 50 MHz); must be >= 2.
MAX_RETRY, 3, failed attempts tolerated before entering ERROR (range 1..7).
SAMPLE_RATE, 8'd100, value sent after the 0xF3 command.
AUTO_START, 1, when 1 the sequence starts in the first cycle after reset release.

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
start_i  in  1  single-cycle pulse; (re)start the sequence; ignored while busy_o=1
tx_req_o  out  1  byte transmit request, level, held until tx_done_i
tx_byte_o  out  8  byte to send; stable while tx_req_o=1
tx_done_i  in  1  single-cycle pulse; transceiver finished sending the byte
tx_err_i  in  1  single-cycle pulse; transmit failed (no device clock or line ack)
rx_valid_i  in  1  single-cycle pulse; rx_byte_i holds a received byte
rx_byte_i  in  8  received byte
stream_en_o  out  1  1 only in STREAM
busy_o  out  1  1 in every state except IDLE, STREAM, ERROR
err_o  out  1  1 only in ERROR
err_code_o  out  3  cause of the most recent failure: 0 none, 1 timeout, 2 tx_err, 3 0xFC, 4 unexpected byte, 5 repeated 0xFE

Behaviour:
- Reset: all outputs 0; state IDLE; retry_cnt 0; timer 0.
- Start:
  - AUTO_START=1: leave IDLE in the first clock after reset release.
  - Otherwise leave IDLE on start_i.
  - start_i in STREAM or ERROR restarts: clears retry_cnt and err_code_o, drops stream_en_o/err_o next cycle.
- Transmit states: tx_req_o=1 and tx_byte_o set one cycle after entering the state.
  - tx_done_i: tx_req_o=0 next cycle, then go to the matching wait state.
  - tx_err_i: failure, code 2.
  - tx_done_i and tx_err_i in the same cycle: tx_err_i wins.
- Sequence:
  - SEND 0xFF -> WAIT_ACK -> WAIT_BAT (expect 0xAA) -> WAIT_ID (expect 0x00)
  - -> SEND 0xF3 -> WAIT_ACK -> SEND SAMPLE_RATE -> WAIT_ACK
  - -> SEND 0xF4 -> WAIT_ACK -> STREAM.
- WAIT_ACK, on rx_valid_i:
  - 0xFA: advance.
  - 0xFE: resend the same byte, retry_cnt+1; on exhaustion the failure code is 5.
  - 0xFC: failure, code 3.
  - Any other byte: failure, code 4.
- WAIT_BAT / WAIT_ID: expected byte advances; 0xFC or any other byte is a failure, code 4 (3 if 0xFC).
- Timer:
  - Clears on entry to every SEND and WAIT state and counts each cycle.
  - Reaching TIMEOUT_CYCLES-1 without the awaited event is a failure, code 1.
  - rx_valid_i/tx_done_i in the same cycle as timeout: the event wins.
- Failure:
  - err_code_o updated.
  - If retry_cnt == MAX_RETRY-1: go to ERROR. Otherwise retry_cnt+1 and restart at SEND 0xFF (except the 0xFE case).
  - retry_cnt counts across the whole sequence; it is never cleared mid-sequence.
- Ignored events: rx_valid_i in SEND states, IDLE, STREAM and ERROR (mouse packets are not interpreted here); tx_done_i/tx_err_i outside SEND states.
- ERROR: holds until start_i or reset.
- Reset mid-transmission: tx_req_o drops immediately (asynchronous).
- Registered outputs only; no combinational path from inputs to outputs.

Decomposition:
- Package ps2_mouse_pkg holds:
  - command constants: CMD_RESET 8'hFF, CMD_SET_RATE 8'hF3, CMD_ENABLE 8'hF4
  - response constants: RSP_ACK 8'hFA, RSP_RESEND 8'hFE, RSP_ERR 8'hFC, RSP_BAT_OK 8'hAA, RSP_ID 8'h00
  - state enum
  - err_code enum
- One sub-module ps2_timeout_timer (clear, enable, expired pulse; width $clog2(TIMEOUT_CYCLES)).

Test Plan:
1. Happy path, TIMEOUT_CYCLES=1000, auto start:
   - Stimulus: model acks every byte with 0xFA, sends 0xAA then 0x00 after reset.
   - Required: tx bytes FF,F3,64,F4 in order; stream_en_o=1; busy_o=0; err_code_o=0.
2. Resend:
   - Stimulus: first reply to 0xF3 is 0xFE.
   - Required: 0xF3 is sent again, sequence completes, exactly 5 tx_done pulses total.
3. Timeout exhaustion, MAX_RETRY=3:
   - Stimulus: model never answers.
   - Required: exactly three 0xFF transmissions, then err_o=1, err_code_o=1, stream_en_o=0, tx_req_o=0.
4. Bad BAT:
   - Stimulus: reply 0xFC instead of 0xAA once.
   - Required: restart at 0xFF, completes, err_code_o=3 retained until next start_i.
5. Recovery and ignore rules:
   - Stimulus: start_i in ERROR with a good model; rx_valid_i=1, rx_byte_i=0x08 while in STREAM.
   - Required: busy_o=1 next cycle, reaches STREAM, err_o=0; STREAM stays with no tx_req_o.
6. Reset mid-transmission:
   - Stimulus: rstn_i=0 during tx_req_o=1; tx_done_i coincident with the timeout cycle.
   - Required: all outputs 0 asynchronously; coincident tx_done_i advances with no failure.
